sparse_weight_packer: RTL and testbench

SPARSE_WEIGHT_PACKER -- requirements
Module: sparse_weight_packer

---
 rtl/sparse_weight_packer_pkg.sv | 14 +
 rtl/sparse_weight_packer.sv | 103 ++++++++++
 tb/tb_sparse_weight_packer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sparse_weight_packer_pkg.sv
// rtl/sparse_weight_packer_pkg.sv - shared state encoding and default block geometry
package sparse_weight_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // Shared with the DP1M4 row so packer and row agree on block shape.
  localparam int BW_DEFAULT    = 4;
  localparam int NNZ_DEFAULT   = 8;
  localparam int TOTAL_DEFAULT = 16;

endpackage

// File: rtl/sparse_weight_packer.sv
// rtl/sparse_weight_packer.sv - packs a dense weight block into nnz slots plus a position mask
module sparse_weight_packer
  import sparse_weight_packer_pkg::*;
#(
  parameter int bw    = BW_DEFAULT,
  parameter int nnz   = NNZ_DEFAULT,
  parameter int total = TOTAL_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [bw-1:0]       w_data,
  input  logic                w_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                load,
  output logic [nnz*bw-1:0]   weights_flat,
  output logic [total-1:0]    weight_mask,
  output logic                overflow
);

  localparam int POS_W = $clog2(total + 1);
  localparam int NZC_W = $clog2(nnz + 1);
  localparam logic [total-1:0] MASK_ONE = total'(1);

  state_t             state_q;
  logic [POS_W-1:0]   pos_q;
  logic [NZC_W-1:0]   nzc_q;
  logic [total-1:0]   mask_q;
  logic               overflow_q;

  logic accept;
  logic nonzero;
  logic slot_we;
  logic done_beat;

  // Gating with reset keeps w_ready low during reset yet high on the first cycle after release.
  assign w_ready   = reset & (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign load      = out_valid & out_ready;

  assign accept    = w_valid & w_ready;
  assign nonzero   = accept && (w_data != '0);
  assign slot_we   = nonzero && (nzc_q < NZC_W'(nnz));
  assign done_beat = accept && (w_last || (pos_q == POS_W'(total - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      pos_q      <= '0;
      nzc_q      <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            pos_q <= pos_q + POS_W'(1);
            if (slot_we) begin
              nzc_q  <= nzc_q + NZC_W'(1);
              mask_q <= mask_q | (MASK_ONE << pos_q);
            end else if (nonzero) begin
              overflow_q <= 1'b1;
            end
            if (done_beat) state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_q    <= COLLECT;
            pos_q      <= '0;
            nzc_q      <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Each slot only ever captures the nonzero that arrives while nzc points at it.
  for (genvar k = 0; k < nnz; k++) begin : g_slot
    logic [bw-1:0] slot_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_q <= '0;
      end else if (load) begin
        slot_q <= '0;
      end else if (slot_we && (nzc_q == NZC_W'(k))) begin
        slot_q <= w_data;
      end
    end

    assign weights_flat[k*bw +: bw] = slot_q;
  end

  assign weight_mask = mask_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sparse_weight_packer.sv
// tb/tb_sparse_weight_packer.sv - self-checking bench for sparse_weight_packer
module tb_sparse_weight_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_data;
  logic        w_last;
  logic        out_valid;
  logic        out_ready;
  logic        load;
  logic [31:0] weights_flat;
  logic [15:0] weight_mask;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  sparse_weight_packer #(.bw(4), .nnz(8), .total(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_last       (w_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .load         (load),
    .weights_flat (weights_flat),
    .weight_mask  (weight_mask),
    .overflow     (overflow)
  );

  always @(posedge clk) if (reset && load) load_cnt++;

  typedef struct {
    string       name;
    int          n;
    bit          use_last;
    logic [63:0] d;
    logic [15:0] mask;
    logic [31:0] flat;
    bit          ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the dense positions, keep the first eight nonzeros in order.
  function automatic void model(input logic [63:0] d, input int n,
                                output logic [15:0] mask, output logic [31:0] flat,
                                output bit ovf);
    int cnt;
    logic [3:0] v;
    mask = '0; flat = '0; ovf = 1'b0; cnt = 0;
    for (int j = 0; j < n; j++) begin
      v = d[j*4 +: 4];
      if (v != 4'd0) begin
        if (cnt < 8) begin
          flat[cnt*4 +: 4] = v;
          mask[j] = 1'b1;
          cnt++;
        end else begin
          ovf = 1'b1;
        end
      end
    end
  endfunction

  task automatic send_beats(input string name, input logic [63:0] d, input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      check({name, " w_ready"}, w_ready, 1);
      check({name, " out_valid_low"}, out_valid, 0);
      w_valid = 1'b1;
      w_data  = d[i*4 +: 4];
      w_last  = use_last && (i == n - 1);
      @(posedge clk);
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = '0;
  endtask

  task automatic finish_block(input string name, input logic [15:0] mask, input logic [31:0] flat,
                              input bit ovf, input int bp);
    int lc0;
    check({name, " out_valid"}, out_valid, 1);
    check({name, " w_ready_emit"}, w_ready, 0);
    check({name, " mask"}, weight_mask, mask);
    check({name, " flat"}, weights_flat, flat);
    check({name, " overflow"}, overflow, ovf);
    for (int c = 0; c < bp; c++) begin
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " bp_load"}, load, 0);
      check({name, " bp_w_ready"}, w_ready, 0);
      check({name, " bp_valid"}, out_valid, 1);
      check({name, " bp_mask"}, weight_mask, mask);
      check({name, " bp_flat"}, weights_flat, flat);
      check({name, " bp_ovf"}, overflow, ovf);
    end
    lc0 = load_cnt;
    out_ready = 1'b1;
    #1;
    check({name, " load"}, load, 1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " load_count"}, load_cnt, lc0 + 1);
    check({name, " cleared_valid"}, out_valid, 0);
    check({name, " cleared_ready"}, w_ready, 1);
    check({name, " cleared_mask"}, weight_mask, 0);
    check({name, " cleared_flat"}, weights_flat, 0);
    check({name, " cleared_ovf"}, overflow, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rst_w_ready"}, w_ready, 0);
    check({name, " rst_out_valid"}, out_valid, 0);
    check({name, " rst_load"}, load, 0);
    check({name, " rst_mask"}, weight_mask, 0);
    check({name, " rst_flat"}, weights_flat, 0);
    check({name, " rst_ovf"}, overflow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [15:0] em;
    logic [31:0] ef;
    bit          eo;
    int          n, lc0;
    bit          ul;

    vecs[0] = '{"alternating", 16, 1'b0, 64'h8070_6050_4030_2010, 16'hAAAA, 32'h8765_4321, 1'b0};
    vecs[1] = '{"all_zero",    16, 1'b0, 64'h0,                   16'h0000, 32'h0,         1'b0};
    vecs[2] = '{"overflow",    16, 1'b0, 64'h0000_00A9_8765_4321, 16'h00FF, 32'h8765_4321, 1'b1};
    vecs[3] = '{"short",        5, 1'b1, 64'h0000_0000_0007_0503, 16'h0015, 32'h0000_0753, 1'b0};

    reset = 1'b0; w_valid = 1'b0; w_data = '0; w_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("power_on");
    reset = 1'b1;
    #1;
    check("first_ready_after_reset", w_ready, 1);
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      send_beats(vecs[v].name, vecs[v].d, vecs[v].n, vecs[v].use_last);
      finish_block(vecs[v].name, vecs[v].mask, vecs[v].flat, vecs[v].ovf, 0);
    end

    send_beats("backpressure", vecs[0].d, 16, 1'b0);
    finish_block("backpressure", vecs[0].mask, vecs[0].flat, vecs[0].ovf, 3);

    lc0 = load_cnt;
    send_beats("abort_collect", 64'h5555_5555_5555_5555, 6, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort_collect");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_collect ready", w_ready, 1);
    check("abort_collect no_load", load_cnt, lc0);
    @(negedge clk);
    send_beats("after_abort", vecs[0].d, 16, 1'b0);
    finish_block("after_abort", vecs[0].mask, vecs[0].flat, vecs[0].ovf, 1);

    lc0 = load_cnt;
    send_beats("abort_emit", vecs[3].d, 5, 1'b1);
    check("abort_emit valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort_emit");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("abort_emit no_load", load_cnt, lc0);
    @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      n  = $urandom_range(1, 16);
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      d  = '0;
      for (int j = 0; j < 16; j++)
        d[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      model(d, n, em, ef, eo);
      send_beats("random", d, n, ul);
      finish_block("random", em, ef, eo, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
